mul_seq: RTL and testbench

Parametrised sequential shift-add multiplier, the next generation of the team's 8-bit `mul`. It multiplies two `WIDTH`-bit operands, either unsigned or two's-complement, selected per operation. It shares the design's external combinational adder (`sum`) through the `sum_in_a`/`sum_in_b`/`sum_out` port trio. It also adds a one-cycle `done` pulse and optional early termination.

---
 rtl/mul_seq_if.sv | 42 ++++
 rtl/mul_seq.sv | 153 +++++++++++++++
 tb/tb_mul_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// mul_seq_if: bundle between a mul_seq multiplier and its environment.
//
// Groups the operation request, the status/result outputs and the
// external adder trio. The parameter WIDTH must match the multiplier.
//
// Handshake: a request is taken on a rising edge where start=1 and
// busy=0. No ready signal is returned. busy=1 means the operand lines are
// not looked at, and a start seen while busy=1 is dropped. Each accepted
// request produces exactly one done pulse. That pulse marks the cycle in
// which result first shows the new product.
//
// Signals:
//   start, signed_i, a_i, b_i  request and operands       (environment -> mul)
//   busy, done, result         status and product         (mul -> environment)
//   sum_in_a, sum_in_b         adder operands             (mul -> adder)
//   sum_out                    adder result (combinational) (adder -> mul)
interface mul_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [2*WIDTH-1:0]   sum_in_a;
  logic [2*WIDTH-1:0]   sum_in_b;
  logic [2*WIDTH-1:0]   sum_out;

  // Environment side: issues requests and hosts the adder.
  modport master (
    output start, signed_i, a_i, b_i, sum_out,
    input  busy, done, result, sum_in_a, sum_in_b
  );

  // Multiplier side.
  modport slave (
    input  start, signed_i, a_i, b_i, sum_out,
    output busy, done, result, sum_in_a, sum_in_b
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier, signed or unsigned per operation.
//
// The multiplier works on operand magnitudes. A final FIX cycle negates
// the product when the signs differ. All additions go through an external
// combinational adder (bus.sum_in_a/sum_in_b -> bus.sum_out).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   bus      mul_seq_if.slave (request, status, result, adder trio)
//   state_o  current FSM state (0 IDLE, 1 CALC, 2 FIX), for observation
//
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to leave CALC as soon as
// the remaining multiplier bits are all zero. Results do not change; only
// the latency does.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_if.slave      bus,
  output logic [1:0]    state_o
);

  localparam int PW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d;
  logic [PW-1:0]    result_q, result_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             last_step;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  always_comb begin
    a_neg = bus.signed_i & bus.a_i[WIDTH-1];
    b_neg = bus.signed_i & bus.b_i[WIDTH-1];
    a_mag = a_neg ? (~bus.a_i) + {{(WIDTH-1){1'b0}}, 1'b1} : bus.a_i;
    b_mag = b_neg ? (~bus.b_i) + {{(WIDTH-1){1'b0}}, 1'b1} : bus.b_i;
  end

  always_comb begin
    last_step = (i_q == IW'(WIDTH - 1));
`ifdef MUL_SEQ_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is zero.
    last_step = last_step | (mb_q[WIDTH-1:1] == '0);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ma_q     <= '0;
      mb_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      i_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    ma_d     = ma_q;
    mb_d     = mb_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    i_d      = i_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ma_d  = a_mag;
          mb_d  = b_mag;
          neg_d = a_neg ^ b_neg;
          acc_d = '0;
          i_d   = '0;
        end
      end
      CALC: begin
        if (mb_q[0]) acc_d = bus.sum_out;
        mb_d = mb_q >> 1;
        i_d  = i_q + 1'b1;
      end
      FIX: begin
        // The adder computes ~acc + 1 in this cycle when neg_q is set.
        result_d = neg_q ? bus.sum_out : acc_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs, including the adder operands.
  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.done     = done_q;
    bus.result   = result_q;
    bus.sum_in_a = '0;
    bus.sum_in_b = '0;
    state_o      = state_q;
    case (state_q)
      CALC: begin
        bus.sum_in_a = acc_q;
        bus.sum_in_b = {{WIDTH{1'b0}}, ma_q} << i_q;
      end
      FIX: begin
        if (neg_q) begin
          bus.sum_in_a = ~acc_q;
          bus.sum_in_b = {{(PW-1){1'b0}}, 1'b1};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq with WIDTH=8.
module tb_mul_seq;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  mul_seq_if #(.WIDTH(8)) bus ();

  // External adder.
  assign bus.sum_out = bus.sum_in_a + bus.sum_in_b;

  mul_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int tests;
  int fails;
  int done_cnt;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got result %0h with no op pending", bus.result);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("result", {16'h0, bus.result}, {16'h0, e});
      end
    end
  end

  // Expected busy length for WIDTH=8.
  function automatic int busy_len(input logic sgn, input logic [7:0] b);
    int n;
    logic [7:0] mb;
    mb = (sgn && b[7]) ? (~b) + 8'd1 : b;
    n = 1;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    for (int k = 0; k < 8; k++) if (mb[k]) n = k + 1;
`else
    n = 8;
`endif
    return n + 1;
  endfunction

  // ---------------- driver ----------------
  // glitch_at > 0 pulses start with fresh operands in that busy cycle.
  task automatic do_op(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int glitch_at);
    int busy_cnt;
    int cyc;
    int d0;
    int blen;
    blen = busy_len(sgn, b);
    cyc = 0;
    while (bus.busy !== 1'b0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    d0 = done_cnt;
    bus.start    = 1'b1;
    bus.signed_i = sgn;
    bus.a_i      = a;
    bus.b_i      = b;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.a_i      = 8'($urandom);
    bus.b_i      = 8'($urandom);
    bus.signed_i = 1'($urandom);
    busy_cnt = 0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      busy_cnt++;
      if (busy_cnt == glitch_at) begin
        bus.start = 1'b1;
        bus.a_i   = 8'($urandom_range(1, 255));
        bus.b_i   = 8'($urandom_range(1, 255));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("busy_len", busy_cnt, blen);
    @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("idle_after", {31'h0, bus.busy}, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{1'b0, 8'd3,   8'd2,   16'd6};
    vecs[1]  = '{1'b0, 8'd5,   8'd5,   16'd25};
    vecs[2]  = '{1'b0, 8'd255, 8'd255, 16'd65025};
    vecs[3]  = '{1'b0, 8'd255, 8'd0,   16'd0};
    vecs[4]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[5]  = '{1'b1, 8'h80,  8'h80,  16'd16384};
    vecs[6]  = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[7]  = '{1'b1, 8'hFF,  8'h00,  16'h0000};
    vecs[8]  = '{1'b0, 8'd200, 8'd1,   16'd200};
    vecs[9]  = '{1'b0, 8'd7,   8'd0,   16'd0};
    vecs[10] = '{1'b0, 8'd1,   8'd128, 16'd128};
    vecs[11] = '{1'b1, 8'hFF,  8'hFF,  16'd1};
    vecs[12] = '{1'b1, 8'h05,  8'hFD,  16'hFFF1};
    vecs[13] = '{1'b0, 8'h80,  8'h80,  16'h4000};
    vecs[14] = '{1'b1, 8'h81,  8'h02,  16'hFF02};
    vecs[15] = '{1'b0, 8'h80,  8'hFF,  16'h7F80};
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    tests = 0;
    fails = 0;
    done_cnt = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.signed_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'h0, bus.busy}, 0);
    check("rst_done",   {31'h0, bus.done}, 0);
    check("rst_result", {16'h0, bus.result}, 0);
    check("rst_sum_a",  {16'h0, bus.sum_in_a}, 0);
    check("rst_sum_b",  {16'h0, bus.sum_in_b}, 0);
    check("rst_state",  {30'h0, state_o}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven directed vectors.
    for (int v = 0; v < NV; v++)
      do_op(vecs[v].sgn, vecs[v].a, vecs[v].b, vecs[v].exp, 0);

    // Random vectors against an integer model.
    for (int r = 0; r < 10; r++) begin
      logic sgn;
      logic [7:0] a, b;
      int x, y, p;
      sgn = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      x = sgn ? int'($signed(a)) : int'(a);
      y = sgn ? int'($signed(b)) : int'(b);
      p = x * y;
      do_op(sgn, a, b, p[15:0], 0);
    end

    // start during busy is ignored.
    do_op(1'b0, 8'd9, 8'd11, 16'd99, 3);
    do_op(1'b1, 8'hF6, 8'd13, 16'hFF7E, 3);

    // Reset during CALC step 4 aborts without done.
    @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i = 8'd100;
    bus.b_i = 8'd255;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_state_calc", {30'h0, state_o}, 1);
    rst = 1'b0;
    #1;
    check("abort_busy",   {31'h0, bus.busy}, 0);
    check("abort_done",   {31'h0, bus.done}, 0);
    check("abort_result", {16'h0, bus.result}, 0);
    check("abort_sum_a",  {16'h0, bus.sum_in_a}, 0);
    check("abort_sum_b",  {16'h0, bus.sum_in_b}, 0);
    check("abort_state",  {30'h0, state_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", {31'h0, bus.busy}, 0);
    do_op(1'b0, 8'd6, 8'd7, 16'd42, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
